// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared state encoding and read-return owner tags for the sram arbiter
package ram_arb_pkg;
    typedef enum logic [1:0] {LOAD, RUN, HALT_WAIT, HALTED} state_t;
    localparam logic [1:0] OWNER_NONE  = 2'd0;
    localparam logic [1:0] OWNER_FLASH = 2'd1;
    localparam logic [1:0] OWNER_CPU   = 2'd2;
    localparam logic [1:0] OWNER_DIAG  = 2'd3;
endpackage

// File: rtl/ram_access_arbiter_if.sv
// ram_access_arbiter_if: requester, CPU bus and sram-side signals of the arbiter
interface ram_access_arbiter_if #(parameter int AW = 16, parameter int DW = 8);
    logic          load_done;
    logic          fl_req, fl_we, fl_gnt;
    logic [AW-1:0] fl_addr;
    logic [DW-1:0] fl_wdata;
    logic          dg_req, dg_we, dg_gnt;
    logic [AW-1:0] dg_addr;
    logic [DW-1:0] dg_wdata;
    logic          cpu_phi2, cpu_sel, cpu_rwbar;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          dg_halt_req;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_cs, ram_we, rd_valid;
    logic [1:0]    rd_owner;
    logic          halted, rdy;
    modport slave (
        input  load_done, fl_req, fl_we, fl_addr, fl_wdata,
        input  dg_req, dg_we, dg_addr, dg_wdata,
        input  cpu_phi2, cpu_sel, cpu_rwbar, cpu_addr, cpu_wdata, dg_halt_req,
        output fl_gnt, dg_gnt, ram_addr, ram_wdata, ram_cs, ram_we,
        output rd_valid, rd_owner, halted, rdy
    );
    modport master (
        output load_done, fl_req, fl_we, fl_addr, fl_wdata,
        output dg_req, dg_we, dg_addr, dg_wdata,
        output cpu_phi2, cpu_sel, cpu_rwbar, cpu_addr, cpu_wdata, dg_halt_req,
        input  fl_gnt, dg_gnt, ram_addr, ram_wdata, ram_cs, ram_we,
        input  rd_valid, rd_owner, halted, rdy
    );
endinterface

// File: rtl/phi2_edge_sync.sv
// phi2_edge_sync: brings the asynchronous CPU phi2 into clk and flags its rising/falling edges
module phi2_edge_sync #(parameter int SYNC_STAGES = 2) (
    input  logic clk,
    input  logic rst_n,
    input  logic phi2,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sr;
    logic                   prev;
    // shift phi2 through the synchroniser and keep one extra copy for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr   <= '0;
            prev <= 1'b0;
        end else begin
            sr   <= {sr[SYNC_STAGES-2:0], phi2};
            prev <= sr[SYNC_STAGES-1];
        end
    end
    assign level = sr[SYNC_STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;
endmodule

// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter: single-port sram owner selection between flash loader, CPU and diagnostics
module ram_access_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AW          = 16,
    parameter int DW          = 8,
    parameter int SYNC_STAGES = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    ram_access_arbiter_if.slave bus
);
    state_t        st, nxt;
    logic          load_seen, load_ok, cpu_en;
    logic          phi2_s, rise, fall, fall_d, rd_hit;
    logic          fl_go, dg_go, cr_go, cw_go;
    logic          w_sel, w_rw;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;
    logic [1:0]    cs_own;

    phi2_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .phi2  (bus.cpu_phi2),
        .level (phi2_s),
        .rise  (rise),
        .fall  (fall)
    );

    // pick the access to launch this cycle and the next ownership state
    always_comb begin
        load_ok = bus.load_done | load_seen;
        cpu_en  = (st == RUN) || (st == HALT_WAIT);
        fl_go   = (st == LOAD) && bus.fl_req && !bus.ram_cs && !load_ok;
        dg_go   = (st == HALTED) && bus.dg_req && !bus.ram_cs;
        cr_go   = cpu_en && rise && bus.cpu_sel && bus.cpu_rwbar;
        cw_go   = cpu_en && fall && w_sel && !w_rw && !rd_hit;
        nxt     = st;
        unique case (st)
            LOAD:      nxt = (load_ok && !bus.ram_cs) ? RUN : LOAD;
            RUN:       nxt = bus.dg_halt_req ? HALT_WAIT : RUN;
            HALT_WAIT: nxt = !bus.dg_halt_req ? RUN : fall_d ? HALTED : HALT_WAIT;
            HALTED:    nxt = bus.dg_halt_req ? HALTED : RUN;
        endcase
    end

    // state, CPU write capture, registered sram strobes and read-return tagging
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st            <= LOAD;
            load_seen     <= 1'b0;
            fall_d        <= 1'b0;
            rd_hit        <= 1'b0;
            w_sel         <= 1'b0;
            w_rw          <= 1'b0;
            w_addr        <= '0;
            w_data        <= '0;
            cs_own        <= OWNER_NONE;
            bus.ram_cs    <= 1'b0;
            bus.ram_we    <= 1'b0;
            bus.ram_addr  <= '0;
            bus.ram_wdata <= '0;
            bus.fl_gnt    <= 1'b0;
            bus.dg_gnt    <= 1'b0;
            bus.rd_valid  <= 1'b0;
            bus.rd_owner  <= OWNER_NONE;
            bus.rdy       <= 1'b0;
            bus.halted    <= 1'b0;
        end else begin
            st        <= nxt;
            load_seen <= load_ok;
            fall_d    <= fall;
            rd_hit    <= rise ? cr_go : rd_hit;
            if (phi2_s) begin
                w_sel  <= bus.cpu_sel;
                w_rw   <= bus.cpu_rwbar;
                w_addr <= bus.cpu_addr;
                w_data <= bus.cpu_wdata;
            end
            bus.ram_cs <= fl_go | dg_go | cr_go | cw_go;
            bus.ram_we <= fl_go ? bus.fl_we : dg_go ? bus.dg_we : cw_go;
            bus.fl_gnt <= fl_go;
            bus.dg_gnt <= dg_go;
            if (fl_go) begin
                bus.ram_addr  <= bus.fl_addr;
                bus.ram_wdata <= bus.fl_wdata;
                cs_own        <= OWNER_FLASH;
            end else if (dg_go) begin
                bus.ram_addr  <= bus.dg_addr;
                bus.ram_wdata <= bus.dg_wdata;
                cs_own        <= OWNER_DIAG;
            end else if (cr_go) begin
                bus.ram_addr  <= bus.cpu_addr;
                cs_own        <= OWNER_CPU;
            end else if (cw_go) begin
                bus.ram_addr  <= w_addr;
                bus.ram_wdata <= w_data;
                cs_own        <= OWNER_CPU;
            end
            bus.rd_valid <= bus.ram_cs & ~bus.ram_we;
            bus.rd_owner <= (bus.ram_cs && !bus.ram_we) ? cs_own : OWNER_NONE;
            bus.rdy      <= (nxt == RUN);
            bus.halted   <= (nxt == HALTED);
        end
    end
endmodule

// File: tb/tb_ram_access_arbiter.sv
// tb_ram_access_arbiter: directed scenarios for flash load, CPU access, halt handshake and diag access
module tb_ram_access_arbiter;
    import ram_arb_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;

    ram_access_arbiter_if #(.AW(16), .DW(8)) bus();
    ram_access_arbiter #(.AW(16), .DW(8), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    wire [32:0] outs = {bus.ram_addr, bus.ram_wdata, bus.ram_cs, bus.ram_we, bus.fl_gnt,
                        bus.dg_gnt, bus.rd_valid, bus.rd_owner, bus.halted, bus.rdy};

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.load_done = 0; bus.fl_req = 0; bus.fl_we = 0; bus.fl_addr = '0; bus.fl_wdata = '0;
        bus.dg_req = 0; bus.dg_we = 0; bus.dg_addr = '0; bus.dg_wdata = '0;
        bus.cpu_phi2 = 0; bus.cpu_sel = 0; bus.cpu_rwbar = 0; bus.cpu_addr = '0;
        bus.cpu_wdata = '0; bus.dg_halt_req = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        repeat (2) tick();
        checks++;
        if (outs !== 33'd0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", outs); end
        rst_n = 1;
        repeat (3) tick();
        checks++;
        if (outs !== 33'd0) begin failures++; $display("FAIL reset_idle_load got=%h exp=0", outs); end
    endtask

    task automatic test_flash();
        bus.fl_req = 1; bus.fl_we = 1; bus.fl_addr = 16'h1234; bus.fl_wdata = 8'hA5;
        tick();
        checks++;
        if ({bus.fl_gnt, bus.ram_cs, bus.ram_we, bus.ram_addr, bus.ram_wdata} !== {3'b111, 16'h1234, 8'hA5}) begin
            failures++;
            $display("FAIL flash_write gnt=%b cs=%b we=%b addr=%h data=%h exp 1 1 1 1234 a5",
                     bus.fl_gnt, bus.ram_cs, bus.ram_we, bus.ram_addr, bus.ram_wdata);
        end
        bus.fl_req = 0;
        tick();
        checks++;
        if ({bus.ram_cs, bus.rd_valid, bus.fl_gnt} !== 3'b000) begin
            failures++;
            $display("FAIL flash_write_end cs=%b rd_valid=%b gnt=%b exp 000", bus.ram_cs, bus.rd_valid, bus.fl_gnt);
        end
        bus.fl_req = 1; bus.fl_we = 0; bus.dg_req = 1; bus.dg_addr = 16'h0BAD;
        tick();
        checks++;
        if ({bus.fl_gnt, bus.dg_gnt, bus.ram_cs, bus.ram_we, bus.ram_addr} !== {4'b1010, 16'h1234}) begin
            failures++;
            $display("FAIL flash_read fl_gnt=%b dg_gnt=%b cs=%b we=%b addr=%h exp 1 0 1 0 1234",
                     bus.fl_gnt, bus.dg_gnt, bus.ram_cs, bus.ram_we, bus.ram_addr);
        end
        tick();
        checks++;
        if ({bus.fl_gnt, bus.ram_cs, bus.rd_valid, bus.rd_owner} !== {3'b001, OWNER_FLASH}) begin
            failures++;
            $display("FAIL flash_read_return gnt=%b cs=%b rd_valid=%b owner=%0d exp 0 0 1 1",
                     bus.fl_gnt, bus.ram_cs, bus.rd_valid, bus.rd_owner);
        end
        bus.fl_req = 0; bus.dg_req = 0;
        tick();
        checks++;
        if ({bus.ram_cs, bus.rd_valid, bus.rd_owner} !== 4'b0000) begin
            failures++;
            $display("FAIL flash_read_done cs=%b rd_valid=%b owner=%0d exp 0 0 0", bus.ram_cs, bus.rd_valid, bus.rd_owner);
        end
    endtask

    task automatic test_load_done();
        int bad = 0;
        bus.fl_req = 1; bus.fl_we = 1; bus.fl_addr = 16'h0042; bus.dg_req = 1; bus.load_done = 1;
        tick();
        checks++;
        if ({bus.rdy, bus.fl_gnt, bus.dg_gnt, bus.ram_cs} !== 4'b1000) begin
            failures++;
            $display("FAIL load_to_run rdy=%b fl_gnt=%b dg_gnt=%b cs=%b exp 1 0 0 0",
                     bus.rdy, bus.fl_gnt, bus.dg_gnt, bus.ram_cs);
        end
        bus.load_done = 0;
        repeat (4) begin
            tick();
            if (!bus.rdy || bus.fl_gnt || bus.dg_gnt || bus.ram_cs) bad++;
        end
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL run_sticky bad_cycles=%0d exp 0", bad); end
        bus.fl_req = 0; bus.dg_req = 0;
    endtask

    task automatic test_cpu_write();
        int cs_n = 0, we_n = 0, rv = 0;
        bus.cpu_sel = 1; bus.cpu_rwbar = 0; bus.cpu_addr = 16'h8000; bus.cpu_wdata = 8'h3C;
        for (int c = 0; c < 300; c++) begin
            bus.cpu_phi2 = (c % 100) < 50;
            tick();
            if (bus.rd_valid) rv++;
            if (bus.ram_cs) begin
                cs_n++;
                if (bus.ram_we) we_n++;
                checks++;
                if (!bus.ram_we || bus.ram_addr !== 16'h8000 || bus.ram_wdata !== 8'h3C || (c % 100) != 52) begin
                    failures++;
                    $display("FAIL cpu_write_pulse we=%b addr=%h data=%h phase=%0d exp 1 8000 3c 52",
                             bus.ram_we, bus.ram_addr, bus.ram_wdata, c % 100);
                end
            end
        end
        checks++;
        if (cs_n != 3 || we_n != 3) begin failures++; $display("FAIL cpu_write_count cs=%0d we=%0d exp 3 3", cs_n, we_n); end
        checks++;
        if (rv != 0) begin failures++; $display("FAIL cpu_write_rdvalid got=%0d exp 0", rv); end
    endtask

    task automatic test_cpu_read();
        int cs_n = 0;
        bus.cpu_rwbar = 1; bus.cpu_addr = 16'h4321;
        for (int c = 0; c < 100; c++) begin
            bus.cpu_phi2 = c < 50;
            tick();
            if (bus.ram_cs) begin
                cs_n++;
                checks++;
                if (bus.ram_we || bus.ram_addr !== 16'h4321 || c != 2) begin
                    failures++;
                    $display("FAIL cpu_read_cs we=%b addr=%h at=%0d exp 0 4321 2", bus.ram_we, bus.ram_addr, c);
                end
            end
            if (c == 3) begin
                checks++;
                if ({bus.rd_valid, bus.rd_owner} !== {1'b1, OWNER_CPU}) begin
                    failures++;
                    $display("FAIL cpu_read_return rd_valid=%b owner=%0d exp 1 2", bus.rd_valid, bus.rd_owner);
                end
            end
        end
        checks++;
        if (cs_n != 1) begin failures++; $display("FAIL cpu_read_count got=%0d exp 1", cs_n); end
    endtask

    task automatic test_halt();
        int halted_at = -1, wr_seen = 0, cs_other = 0, rdy_bad = 0;
        bus.cpu_rwbar = 0; bus.cpu_addr = 16'h8001; bus.cpu_wdata = 8'h5A;
        for (int c = 0; c < 300; c++) begin
            bus.cpu_phi2 = (c % 100) < 50;
            if (c == 20) bus.dg_halt_req = 1;
            if (c == 60) bus.cpu_rwbar = 1;
            tick();
            if (c >= 20 && bus.rdy) rdy_bad++;
            if (bus.halted && halted_at < 0) halted_at = c;
            if (bus.ram_cs) begin
                if (c == 52 && bus.ram_we && bus.ram_addr === 16'h8001 && bus.ram_wdata === 8'h5A && !bus.halted)
                    wr_seen++;
                else
                    cs_other++;
            end
        end
        checks++;
        if (rdy_bad != 0) begin failures++; $display("FAIL halt_rdy_low bad_cycles=%0d exp 0", rdy_bad); end
        checks++;
        if (wr_seen != 1) begin failures++; $display("FAIL halt_write_completes got=%0d exp 1", wr_seen); end
        checks++;
        if (cs_other != 0) begin failures++; $display("FAIL halt_no_cpu_cs got=%0d exp 0", cs_other); end
        checks++;
        if (halted_at != 53) begin failures++; $display("FAIL halt_entry at=%0d exp 53", halted_at); end
        checks++;
        if (bus.halted !== 1'b1) begin failures++; $display("FAIL halt_held got=%b exp 1", bus.halted); end
    endtask

    task automatic test_diag();
        bus.fl_req = 1; bus.dg_req = 1; bus.dg_we = 0; bus.dg_addr = 16'hFFFC;
        tick();
        checks++;
        if ({bus.dg_gnt, bus.fl_gnt, bus.ram_cs, bus.ram_we, bus.ram_addr} !== {4'b1010, 16'hFFFC}) begin
            failures++;
            $display("FAIL diag_read dg_gnt=%b fl_gnt=%b cs=%b we=%b addr=%h exp 1 0 1 0 fffc",
                     bus.dg_gnt, bus.fl_gnt, bus.ram_cs, bus.ram_we, bus.ram_addr);
        end
        bus.dg_req = 0; bus.fl_req = 0;
        tick();
        checks++;
        if ({bus.rd_valid, bus.rd_owner, bus.ram_cs} !== {1'b1, OWNER_DIAG, 1'b0}) begin
            failures++;
            $display("FAIL diag_read_return rd_valid=%b owner=%0d cs=%b exp 1 3 0", bus.rd_valid, bus.rd_owner, bus.ram_cs);
        end
        bus.dg_req = 1; bus.dg_we = 1; bus.dg_addr = 16'h0010; bus.dg_wdata = 8'h77;
        tick();
        checks++;
        if ({bus.dg_gnt, bus.ram_cs, bus.ram_we, bus.ram_addr, bus.ram_wdata} !== {3'b111, 16'h0010, 8'h77}) begin
            failures++;
            $display("FAIL diag_write gnt=%b cs=%b we=%b addr=%h data=%h exp 1 1 1 0010 77",
                     bus.dg_gnt, bus.ram_cs, bus.ram_we, bus.ram_addr, bus.ram_wdata);
        end
        bus.dg_req = 0;
        tick();
        checks++;
        if ({bus.rd_valid, bus.ram_cs} !== 2'b00) begin
            failures++;
            $display("FAIL diag_write_end rd_valid=%b cs=%b exp 0 0", bus.rd_valid, bus.ram_cs);
        end
        bus.dg_halt_req = 0;
        tick();
        checks++;
        if ({bus.rdy, bus.halted} !== 2'b10) begin
            failures++;
            $display("FAIL halt_release rdy=%b halted=%b exp 1 0", bus.rdy, bus.halted);
        end
    endtask

    task automatic test_halt_drop();
        bus.dg_halt_req = 1;
        tick();
        checks++;
        if ({bus.rdy, bus.halted} !== 2'b00) begin
            failures++;
            $display("FAIL halt_wait_enter rdy=%b halted=%b exp 0 0", bus.rdy, bus.halted);
        end
        bus.dg_halt_req = 0;
        tick();
        checks++;
        if ({bus.rdy, bus.halted} !== 2'b10) begin
            failures++;
            $display("FAIL halt_drop_return rdy=%b halted=%b exp 1 0", bus.rdy, bus.halted);
        end
        repeat (3) tick();
        checks++;
        if ({bus.rdy, bus.halted} !== 2'b10) begin
            failures++;
            $display("FAIL halt_drop_stays rdy=%b halted=%b exp 1 0", bus.rdy, bus.halted);
        end
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        rst_n = 0;
        tick();
        rst_n = 1;
        tick();
        bus.fl_req = 1; bus.fl_we = 1; bus.fl_addr = 16'h2000; bus.fl_wdata = 8'h11;
        tick();
        checks++;
        if ({bus.fl_gnt, bus.ram_cs, bus.ram_we} !== 3'b111) begin
            failures++;
            $display("FAIL reload_flash_write gnt=%b cs=%b we=%b exp 1 1 1", bus.fl_gnt, bus.ram_cs, bus.ram_we);
        end
        #2 rst_n = 0;
        #1;
        checks++;
        if ({bus.ram_cs, bus.ram_we, bus.fl_gnt} !== 3'b000) begin
            failures++;
            $display("FAIL reset_async_cs cs=%b we=%b gnt=%b exp 0 0 0", bus.ram_cs, bus.ram_we, bus.fl_gnt);
        end
        idle_inputs();
        tick();
        rst_n = 1;
        repeat (2) tick();
        checks++;
        if (outs !== 33'd0) begin failures++; $display("FAIL reset_back_to_load got=%h exp 0", outs); end
        bus.fl_req = 1; bus.fl_we = 0; bus.fl_addr = 16'h0001;
        tick();
        checks++;
        if ({bus.fl_gnt, bus.rdy, bus.ram_cs} !== 3'b101) begin
            failures++;
            $display("FAIL load_serves_flash gnt=%b rdy=%b cs=%b exp 1 0 1", bus.fl_gnt, bus.rdy, bus.ram_cs);
        end
        bus.fl_req = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_flash();
        test_load_done();
        test_cpu_write();
        test_cpu_read();
        test_halt();
        test_diag();
        test_halt_drop();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
